// File: rtl/snail_pattern_tx.sv
// snail_pattern_tx: MSB-first serial word transmitter with valid/ready load and "11"-pair hit count; ports clk, rst, data_in, load_valid, load_ready, sdo, bit_valid, busy, done, expected_hits; SNAIL_TX_GAP_EN adds a DIV-cycle zero guard after each word
module snail_pattern_tx #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     load_valid,
  output logic                     load_ready,
  output logic                     sdo,
  output logic                     bit_valid,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(WIDTH)-1:0] expected_hits
);
  localparam int unsigned HW = $clog2(WIDTH);
  localparam int unsigned DW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [HW-1:0] BIT_LAST = HW'(WIDTH - 1);
`ifdef SNAIL_TX_GAP_EN
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif
  state_t           state_q;
  logic [WIDTH-1:0] sh_q;
  logic [DW-1:0]    div_q;
  logic [HW-1:0]    bit_q;
  logic [HW-1:0]    hits_q;
  logic [HW-1:0]    hits_d;
  logic             done_q;
  always_comb begin
    hits_d = '0;
    for (int i = 0; i < int'(WIDTH) - 1; i++) hits_d = hits_d + HW'(data_in[i] & data_in[i+1]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      hits_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (load_valid) begin
          sh_q    <= data_in;
          hits_q  <= hits_d;
          div_q   <= '0;
          bit_q   <= '0;
          state_q <= SHIFT;
        end
        SHIFT: if (div_q == DIV_LAST) begin
          div_q <= '0;
          sh_q  <= {sh_q[WIDTH-2:0], 1'b0};
          bit_q <= bit_q + 1'b1;
          if (bit_q == BIT_LAST) begin
`ifdef SNAIL_TX_GAP_EN
            state_q <= GAP;
`else
            state_q <= IDLE;
            done_q  <= 1'b1;
`endif
          end
        end else div_q <= div_q + 1'b1;
`ifdef SNAIL_TX_GAP_EN
        GAP: if (div_q == DIV_LAST) begin
          div_q   <= '0;
          state_q <= IDLE;
          done_q  <= 1'b1;
        end else div_q <= div_q + 1'b1;
`endif
        default: state_q <= IDLE;
      endcase
    end
  end
  assign load_ready    = state_q == IDLE;
  assign busy          = state_q != IDLE;
  assign bit_valid     = state_q != IDLE;
  assign sdo           = state_q == SHIFT && sh_q[WIDTH-1];
  assign done          = done_q;
  assign expected_hits = hits_q;
endmodule
